// File: rtl/hill_cipher_stream.sv
// ----------------------------------------------------------------------------
// hill_cipher_stream
//
// Streaming Hill-cipher engine. ASCII letters arrive on a valid/ready stream
// and are grouped into BLOCK_SIZE-letter blocks. A short final block is padded
// with 'X'. Each block is multiplied, modulo 26, by one of two resident key
// matrices: bank 0 for encrypt, bank 1 for decrypt. The bank is chosen per
// block. Results leave as letters on a backpressured output stream.
//
// Flow: FILL (collect N letters) -> COMPUTE (N*N cycles, one MAC per cycle)
// -> DRAIN (emit N letters) -> FILL. Fill and compute never overlap.
//
// Parameters
//   BLOCK_SIZE  matrix dimension N, legal range 2..8
//   DATA_WIDTH  width of a character or key element, >= 8
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   key_wen/bank/addr    key element write; addr is row-major i*N+j.
//   key_data             the element is stored as key_data % 26, and the
//                        write is applied only while busy = 0.
//   mode                 bank used by the next block (latched on its 1st char)
//   in_data/valid/last   input character stream
//   in_ready             high in FILL
//   out_data/valid/last  output character stream
//   out_ready            sink backpressure
//   busy                 high when a block is in flight or partially filled
//   done                 one-cycle pulse after the final output handshake
//
// Optional feature: define HILL_CASE_PRESERVE_EN to emit each output letter
// in the case of the input letter at the same block position. Pad letters
// count as uppercase. When the macro is undefined, all output is uppercase
// and no case storage exists.
// ----------------------------------------------------------------------------
module hill_cipher_stream #(
  parameter int BLOCK_SIZE = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     key_wen,
  input  logic                                     key_bank,
  input  logic [$clog2(BLOCK_SIZE*BLOCK_SIZE)-1:0] key_addr,
  input  logic [DATA_WIDTH-1:0]                    key_data,
  input  logic                                     mode,
  input  logic [DATA_WIDTH-1:0]                    in_data,
  input  logic                                     in_valid,
  input  logic                                     in_last,
  output logic                                     in_ready,
  output logic [DATA_WIDTH-1:0]                    out_data,
  output logic                                     out_valid,
  output logic                                     out_last,
  input  logic                                     out_ready,
  output logic                                     busy,
  output logic                                     done
);

  localparam int N    = BLOCK_SIZE;
  localparam int W    = DATA_WIDTH;
  localparam int NN   = N * N;
  localparam int AW   = $clog2(NN);
  localparam int CW   = $clog2(N);
  localparam int ACCW = 2 * W + CW;

  localparam logic [W-1:0] CH_UA   = W'(65);   // 'A'
  localparam logic [W-1:0] CH_UZ   = W'(90);   // 'Z'
  localparam logic [W-1:0] CH_LA   = W'(97);   // 'a'
  localparam logic [W-1:0] CH_LZ   = W'(122);  // 'z'
  localparam logic [4:0]   PAD_IDX = 5'd23;    // 'X'

  typedef enum logic [1:0] {FILL, COMPUTE, DRAIN} state_t;

  state_t          state, state_next;
  logic [4:0]      key_mem   [2][NN];
  logic [4:0]      in_block  [N];
  logic [4:0]      out_block [N];
  logic [CW-1:0]   fill_cnt, i_cnt, j_cnt, k_cnt, k_next;
  logic [AW-1:0]   kptr;            // row-major key index, tracks i*N+j
  logic [ACCW-1:0] acc, prod, mac_sum;
  logic [4:0]      mac_mod, key_mod;
  logic            bank_sel, last_flag;
  logic            in_fire, out_fire, fill_end, compute_end, drain_end;
  logic            key_wr_en;

  // Letters map case-insensitively to 0..25. Every other character maps to 0.
  function automatic logic [4:0] letter_idx(input logic [W-1:0] c);
    if (c >= CH_UA && c <= CH_UZ) return 5'(c - CH_UA);
    if (c >= CH_LA && c <= CH_LZ) return 5'(c - CH_LA);
    return 5'd0;
  endfunction

  function automatic logic [W-1:0] to_ascii(input logic [4:0] idx, input logic lower);
    return (lower ? CH_LA : CH_UA) + W'(idx);
  endfunction

  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign fill_end    = (state == FILL) && in_fire && (in_last || fill_cnt == CW'(N - 1));
  assign compute_end = (state == COMPUTE) && (kptr == AW'(NN - 1));
  assign drain_end   = (state == DRAIN) && out_fire && (k_cnt == CW'(N - 1));
  assign k_next      = k_cnt + CW'(1);

  assign prod    = ACCW'(key_mem[bank_sel][kptr]) * ACCW'(in_block[j_cnt]);
  assign mac_sum = acc + prod;
  assign mac_mod = 5'(mac_sum % ACCW'(26));

  assign key_mod   = 5'(key_data % W'(26));
  assign key_wr_en = key_wen && !busy && (key_addr <= AW'(NN - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every clocked register uses non-blocking assignment, so all
    // flops update together from values that were sampled before the edge.
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: the default comes first. Every path then assigns state_next,
    // so no latch is inferred.
    state_next = state;
    unique case (state)
      FILL:    if (fill_end)    state_next = COMPUTE;
      COMPUTE: if (compute_end) state_next = DRAIN;
      DRAIN:   if (drain_end)   state_next = FILL;
      default:                  state_next = FILL;
    endcase
  end

  // ---------------------------------------------------------------- keys
  // Both banks power up as identity. A reset therefore restores keys that
  // pass text through unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int e = 0; e < NN; e++)
          key_mem[b][e] <= (e % (N + 1) == 0) ? 5'd1 : 5'd0;
    end else if (key_wr_en) begin
      key_mem[key_bank][key_addr] <= key_mod;
    end
  end

  // ---------------------------------------------------------------- buffers
  // NOTE: the block buffers have no reset. Every position is written
  // (either loaded or padded) before it is read.
  always_ff @(posedge clk) begin
    if (state == FILL && in_fire) begin
      in_block[fill_cnt] <= letter_idx(in_data);
      if (in_last)
        for (int p = 0; p < N; p++)
          if (CW'(p) > fill_cnt) in_block[p] <= PAD_IDX;
    end
    if (state == COMPUTE && j_cnt == CW'(N - 1))
      out_block[i_cnt] <= mac_mod;
  end

`ifdef HILL_CASE_PRESERVE_EN
  logic [N-1:0] case_lower;
  always_ff @(posedge clk) begin
    if (state == FILL && in_fire) begin
      case_lower[fill_cnt] <= (in_data >= CH_LA) && (in_data <= CH_LZ);
      if (in_last)
        for (int p = 0; p < N; p++)
          if (CW'(p) > fill_cnt) case_lower[p] <= 1'b0;
    end
  end
`else
  logic [N-1:0] case_lower;
  assign case_lower = '0;
`endif

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt  <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      k_cnt     <= '0;
      kptr      <= '0;
      acc       <= '0;
      bank_sel  <= 1'b0;
      last_flag <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      in_ready <= (state_next == FILL);
      busy     <= (state_next != FILL) || (state == FILL && (fill_cnt != '0 || in_fire));
      done     <= drain_end && last_flag;

      unique case (state)
        FILL: begin
          if (in_fire) begin
            if (fill_cnt == '0) bank_sel  <= mode;
            if (in_last)        last_flag <= 1'b1;
            if (!fill_end)      fill_cnt  <= fill_cnt + CW'(1);
          end
        end
        COMPUTE: begin
          if (compute_end) begin
            // Row 0 finished long before the last product, so the first
            // output letter can be presented on this same edge.
            kptr      <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            acc       <= '0;
            k_cnt     <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_data  <= to_ascii(out_block[0], case_lower[0]);
          end else begin
            kptr <= kptr + AW'(1);
            if (j_cnt == CW'(N - 1)) begin
              acc   <= '0;
              j_cnt <= '0;
              i_cnt <= i_cnt + CW'(1);
            end else begin
              acc   <= mac_sum;
              j_cnt <= j_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (k_cnt == CW'(N - 1)) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              fill_cnt  <= '0;
              last_flag <= 1'b0;
              k_cnt     <= '0;
            end else begin
              k_cnt    <= k_next;
              out_data <= to_ascii(out_block[k_next], case_lower[k_next]);
              out_last <= last_flag && (k_next == CW'(N - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hill_cipher_stream.sv
// ----------------------------------------------------------------------------
// tb_hill_cipher_stream
//
// Self-checking bench for hill_cipher_stream (N = 3, 8-bit characters).
// The reference model works at the message level. It splits the message into
// blocks, pads them with 'X', and forms each matrix-vector product mod 26
// from a key model that tracks every write the DUT is expected to accept.
// A monitor collects output handshakes. It also checks output stability
// under stall and the timing of the done pulse.
// ----------------------------------------------------------------------------
module tb_hill_cipher_stream;
  localparam int N  = 3;
  localparam int W  = 8;
  localparam int AW = $clog2(N * N);

`ifdef HILL_CASE_PRESERVE_EN
  localparam bit CASE_EN = 1'b1;
`else
  localparam bit CASE_EN = 1'b0;
`endif

  typedef logic [7:0] chq_t [$];

  logic          clk = 1'b0;
  logic          rst;
  logic          key_wen, key_bank;
  logic [AW-1:0] key_addr;
  logic [W-1:0]  key_data;
  logic          mode;
  logic [W-1:0]  in_data;
  logic          in_valid, in_last, in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid, out_last, out_ready;
  logic          busy, done;

  hill_cipher_stream #(.BLOCK_SIZE(N), .DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_wen  (key_wen),
    .key_bank (key_bank),
    .key_addr (key_addr),
    .key_data (key_data),
    .mode     (mode),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------- model
  int         key_m [2][N][N];
  logic [8:0] exp_q [$];   // {last, char}
  logic [8:0] got_q [$];

  function automatic void key_identity();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          key_m[b][i][j] = (i == j) ? 1 : 0;
  endfunction

  function automatic int letter(input int c);
    if (c >= 65 && c <= 90)  return c - 65;
    if (c >= 97 && c <= 122) return c - 97;
    return 0;
  endfunction

  function automatic void model_msg(input chq_t msg, input logic bank);
    int v  [N];
    bit lc [N];
    int len  = msg.size();
    int nblk = (len + N - 1) / N;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < N; j++) begin
        int p = b * N + j;
        if (p < len) begin
          v[j]  = letter(int'(msg[p]));
          lc[j] = (msg[p] >= 8'd97) && (msg[p] <= 8'd122);
        end else begin
          v[j]  = 23;
          lc[j] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        int sum = 0;
        for (int j = 0; j < N; j++) sum += key_m[bank][i][j] * v[j];
        sum = sum % 26;
        exp_q.push_back({(b == nblk - 1) && (i == N - 1),
                         8'(((CASE_EN && lc[i]) ? 97 : 65) + sum)});
      end
    end
  endfunction

  function automatic chq_t str_to_q(input string s);
    chq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // ---------------------------------------------------------------- monitor
  int         cyc = 0;
  int         rise_cycle = 0;
  int         last_hs_cycle = 0;
  int         done_cnt = 0;
  int         ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
  logic       prev_valid = 1'b0, stall_prev = 1'b0, prev_last_fire = 1'b0;
  logic [8:0] stall_word = '0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_valid     = 1'b0;
      stall_prev     = 1'b0;
      prev_last_fire = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_word", {out_last, out_data}, stall_word);
      end
      if (done || prev_last_fire) check("done_timing", done, prev_last_fire);
      if (done) done_cnt++;
      if (out_valid && !prev_valid) rise_cycle = cyc + 1;
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      stall_prev     = out_valid && !out_ready;
      stall_word     = {out_last, out_data};
      prev_last_fire = out_valid && out_ready && out_last;
      prev_valid     = out_valid;
    end
  end

  // ---------------------------------------------------------------- drivers
  // All tasks start and end 1 time unit after a rising edge.
  task automatic write_key(input logic bank, input int addr, input int data, input bit applied);
    key_wen  = 1'b1;
    key_bank = bank;
    key_addr = AW'(addr);
    key_data = W'(data);
    @(posedge clk); #1;
    key_wen = 1'b0;
    if (applied) key_m[bank][addr / N][addr % N] = data % 26;
  endtask

  task automatic load_key(input logic bank, input int k [N*N]);
    for (int e = 0; e < N * N; e++) write_key(bank, e, k[e], 1'b1);
  endtask

  task automatic send_msg(input chq_t msg, input logic bank, input int gap_max);
    int len = msg.size();
    model_msg(msg, bank);
    for (int i = 0; i < len; i++) begin
      int waited = 0;
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        mode     = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = msg[i];
      in_last  = (i == len - 1);
      // Only the first letter of a block sets the bank; others carry noise.
      mode     = (i % N == 0) ? bank : 1'($urandom_range(0, 1));
      @(negedge clk);
      while (!in_ready && waited < 300) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
      if (i == len - 1) last_hs_cycle = cyc + 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_msg(input string tag);
    int budget = 0;
    while (got_q.size() < exp_q.size() && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_c%0d", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_idle"}, busy, 0);
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  // ---------------------------------------------------------------- stimulus
  int enc_key [N*N];
  int dec_key [N*N];
  int rnd_key [N*N];
  int edge_ch [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; key_wen = 1'b0; key_bank = 1'b0; key_addr = '0; key_data = '0;
    mode = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    enc_key = '{6, 24, 1, 13, 16, 10, 20, 17, 15};
    dec_key = '{8, 5, 10, 21, 8, 21, 21, 12, 8};
    edge_ch = '{64, 91, 96, 123, 48, 32};   // neighbours of the letter ranges
    key_identity();

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    // Identity keys: HEL / LOX, with out_last on the pad.
    send_msg(str_to_q("HELLO"), 1'b0, 0);
    finish_msg("hello");

    // Encrypt, and check the first-output latency.
    load_key(1'b0, enc_key);
    send_msg(str_to_q("ACT"), 1'b0, 0);
    finish_msg("enc_act");
    check("latency", rise_cycle - last_hs_cycle, N * N + 1);

    // Decrypt bank; bank 0 must still hold the encrypt key.
    load_key(1'b1, dec_key);
    send_msg(str_to_q("POH"), 1'b1, 0);
    finish_msg("dec_poh");
    send_msg(str_to_q("ACT"), 1'b0, 0);
    finish_msg("bank0_kept");

    // Two blocks, the second one padded: POHPAW.
    send_msg(str_to_q("ACTC"), 1'b0, 1);
    finish_msg("pad_actc");

    // Backpressure, with a key write while draining that must be ignored.
    ready_mode = 1;
    send_msg(str_to_q("ACT"), 1'b0, 0);
    begin
      int budget = 0;
      while (!out_valid && budget < 100) begin
        @(posedge clk); #1;
        budget++;
      end
    end
    check("drain_busy", busy, 1);
    write_key(1'b0, 0, 5, 1'b0);
    finish_msg("bp_act");
    ready_mode = 0;
    send_msg(str_to_q("ACT"), 1'b0, 0);
    finish_msg("after_ignored_write");

    // Lower-case input.
    send_msg(str_to_q("act"), 1'b0, 0);
    finish_msg("case_act");

    // Reset during COMPUTE: no output, keys back to identity.
    send_msg(str_to_q("ACT"), 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    key_identity();
    repeat (N * N + 2 * N) @(posedge clk);
    #1;
    check("abort_no_output", got_q.size(), 0);
    check("abort_no_done", done_cnt, 0);
    check("abort_in_ready_back", in_ready, 1);
    send_msg(str_to_q("AB"), 1'b0, 0);
    finish_msg("post_abort_ab");

    // Randomized messages, keys and backpressure.
    for (int r = 0; r < 12; r++) begin
      chq_t msg;
      int   len;
      if ($urandom_range(0, 1) == 1) begin
        for (int e = 0; e < N * N; e++) rnd_key[e] = $urandom_range(0, 255);
        load_key(1'($urandom_range(0, 1)), rnd_key);
      end
      ready_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 4))
          0, 1:    msg.push_back(8'(65 + $urandom_range(0, 25)));
          2, 3:    msg.push_back(8'(97 + $urandom_range(0, 25)));
          default: msg.push_back(8'(edge_ch[$urandom_range(0, 5)]));
        endcase
      end
      send_msg(msg, 1'($urandom_range(0, 1)), 2);
      finish_msg($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
